// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA bus arbiter.
//   arb_state_e  : bus ownership state (CPU_OWN, HANDOFF, DMA_OWN, RELEASE)
//   NUM_DMA_CH   : number of DMA requesters
//   DEF_CPU_SLOT : default guaranteed CPU cycles after each DMA release
package dma_arb_pkg;

    localparam int NUM_DMA_CH   = 4;
    localparam int DEF_CPU_SLOT = 2;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        HANDOFF = 2'd1,
        DMA_OWN = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dma_prio_enc.sv
// Fixed-priority encoder: the lowest-index bit of (req & ~excl) wins.
// Ports:
//   req   in  NUM_CH  request vector
//   excl  in  NUM_CH  bits removed from the competition
//   win   out NUM_CH  one-hot winner, zero when nothing is left
//   valid out 1       some bit survived the exclusion
// Purely combinational.
module dma_prio_enc
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = NUM_DMA_CH
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] excl,
    output logic [NUM_CH-1:0] win,
    output logic              valid
);

    logic [NUM_CH-1:0] cand;

    assign cand  = req & ~excl;
    assign valid = |cand;

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Registered owner controller for the shared system memory bus.
// Pauses the CPU, grants one DMA channel at a time (channel 0 highest
// priority, preemption only at unit boundaries) and hands the bus back
// to the CPU for at least CPU_SLOT cycles after every DMA release.
// Ports:
//   clk, rst_b    clock; asynchronous active-low reset
//   dma_req       per-channel pending-transfer level
//   unit_done     per-channel pulse: one read+write unit finished
//   chan_done     per-channel pulse: whole transfer finished
//   mem_wait      memory busy; bus owner is frozen while high
//   cpu_paused    CPU is stalled at an access boundary
//   cpu_pause     stall request to the CPU
//   grant         one-hot channel grant
//   bus_sel_dma   bus mux select, 1 = DMA drives the bus
//   dma_active    any grant asserted
//   preempt_evt   one-cycle pulse on a priority preemption
// Handshake: a grant is only issued once cpu_pause and cpu_paused are
// both high and mem_wait is low; the owner only changes on a cycle with
// mem_wait low, and done pulses seen while mem_wait is high are dropped.
module dma_bus_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH   = NUM_DMA_CH,
    parameter int CPU_SLOT = DEF_CPU_SLOT
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [NUM_CH-1:0] dma_req,
    input  logic [NUM_CH-1:0] unit_done,
    input  logic [NUM_CH-1:0] chan_done,
    input  logic              mem_wait,
    input  logic              cpu_paused,
    output logic              cpu_pause,
    output logic [NUM_CH-1:0] grant,
    output logic              bus_sel_dma,
    output logic              dma_active,
    output logic              preempt_evt
);

    // A zero-length slot still needs a 1-bit counter to exist.
    localparam int                CNT_W     = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;
    localparam logic [CNT_W-1:0]  SLOT_LOAD = CNT_W'(CPU_SLOT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              cpu_pause_q, cpu_pause_d;
    logic              bus_sel_q, bus_sel_d;
    logic              dma_active_q, dma_active_d;
    logic              preempt_q, preempt_d;

    logic [NUM_CH-1:0] pick_excl, pick_win;
    logic [NUM_CH-1:0] hi_excl, hi_win;
    logic              pick_vld, hi_vld;
    logic              g_chan_done, g_unit_done, g_req;

    // Normal pick: any requester, minus the current owner while one exists.
    assign pick_excl = (state_q == DMA_OWN) ? grant_q : '0;
    // Higher-than-g pick: g-1 is the mask of indices below the one-hot g,
    // so its complement removes g and everything of lower priority.
    assign hi_excl   = ~(grant_q - CH_ONE);

    dma_prio_enc #(.NUM_CH(NUM_CH)) u_pick (
        .req   (dma_req),
        .excl  (pick_excl),
        .win   (pick_win),
        .valid (pick_vld)
    );

    dma_prio_enc #(.NUM_CH(NUM_CH)) u_hi_pick (
        .req   (dma_req),
        .excl  (hi_excl),
        .win   (hi_win),
        .valid (hi_vld)
    );

    // Events on non-granted channels are masked off here.
    assign g_chan_done = |(chan_done & grant_q);
    assign g_unit_done = |(unit_done & grant_q);
    assign g_req       = |(dma_req & grant_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        cpu_pause_d = cpu_pause_q;
        preempt_d   = 1'b0;

        case (state_q)
            CPU_OWN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if ((|dma_req) && (cnt_q == '0)) begin
                    cpu_pause_d = 1'b1;
                    state_d     = HANDOFF;
                end
            end
            HANDOFF: begin
                cpu_pause_d = 1'b1;
                if (dma_req == '0) begin
                    cpu_pause_d = 1'b0;
                    state_d     = CPU_OWN;
                end else if (cpu_paused && !mem_wait) begin
                    grant_d = pick_win;
                    state_d = DMA_OWN;
                end
            end
            DMA_OWN: begin
                if (!mem_wait) begin
                    // chan_done or a dropped request ends the channel and
                    // takes precedence over a simultaneous unit_done.
                    if (g_chan_done || !g_req) begin
                        if (pick_vld) begin
                            grant_d = pick_win;
                        end else begin
                            grant_d = '0;
                            state_d = RELEASE;
                        end
                    end else if (g_unit_done && hi_vld) begin
                        grant_d   = hi_win;
                        preempt_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                cpu_pause_d = 1'b0;
                cnt_d       = SLOT_LOAD;
                state_d     = CPU_OWN;
            end
            default: begin
                grant_d     = '0;
                cpu_pause_d = 1'b0;
                state_d     = CPU_OWN;
            end
        endcase

        bus_sel_d    = (state_d == DMA_OWN);
        dma_active_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= CPU_OWN;
            cnt_q        <= '0;
            grant_q      <= '0;
            cpu_pause_q  <= 1'b0;
            bus_sel_q    <= 1'b0;
            dma_active_q <= 1'b0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            cpu_pause_q  <= cpu_pause_d;
            bus_sel_q    <= bus_sel_d;
            dma_active_q <= dma_active_d;
            preempt_q    <= preempt_d;
        end
    end

    assign cpu_pause   = cpu_pause_q;
    assign grant       = grant_q;
    assign bus_sel_dma = bus_sel_q;
    assign dma_active  = dma_active_q;
    assign preempt_evt = preempt_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter. The stimulus thread pushes each
// expected output-vector change together with the cycle it must appear in;
// a monitor thread pops and compares whenever the outputs change.
// Output vector layout: {preempt_evt, dma_active, bus_sel_dma, cpu_pause, grant[3:0]}.
module tb_dma_bus_arbiter;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [3:0] dma_req;
    logic [3:0] unit_done;
    logic [3:0] chan_done;
    logic       mem_wait;
    logic       cpu_paused;
    logic       cpu_pause;
    logic [3:0] grant;
    logic       bus_sel_dma;
    logic       dma_active;
    logic       preempt_evt;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] out_vec;
    logic [W-1:0] prev_out;

    assign out_vec = {preempt_evt, dma_active, bus_sel_dma, cpu_pause, grant};

    dma_bus_arbiter #(.NUM_CH(4), .CPU_SLOT(2)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .dma_req     (dma_req),
        .unit_done   (unit_done),
        .chan_done   (chan_done),
        .mem_wait    (mem_wait),
        .cpu_paused  (cpu_paused),
        .cpu_pause   (cpu_pause),
        .grant       (grant),
        .bus_sel_dma (bus_sel_dma),
        .dma_active  (dma_active),
        .preempt_evt (preempt_evt)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk(input logic pre, input logic act,
                                        input logic sel, input logic pau,
                                        input logic [3:0] g);
        return {pre, act, sel, pau, g};
    endfunction

    task automatic push_exp(input logic [W-1:0] v, input int c);
        exp_q.push_back(v);
        exp_cyc_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    initial begin
        int c;
        rst_b      = 1'b1;
        dma_req    = '0;
        unit_done  = '0;
        chan_done  = '0;
        mem_wait   = 1'b0;
        cpu_paused = 1'b0;
        prev_out   = '0;

        // Monitor: compares every change of the output vector against the scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (out_vec !== prev_out) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_change cyc=%0d got=%b required=no change from %b",
                                 cyc, out_vec, prev_out);
                    end else begin
                        logic [W-1:0] e;
                        int           ec;
                        e  = exp_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        if (out_vec !== e || cyc != ec) begin
                            failures++;
                            $display("FAIL out_event got=%b at cyc %0d required=%b at cyc %0d",
                                     out_vec, cyc, e, ec);
                        end
                    end
                    prev_out = out_vec;
                end
            end
        join_none

        // Reset.
        #1 rst_b = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", out_vec, '0);
        rst_b = 1'b1;
        tick();
        chk("idle_no_request", out_vec, '0);

        // Single request, cpu already paused: pause at +1, grant at +2.
        c = cyc;
        cpu_paused = 1'b1;
        dma_req    = 4'b0100;
        push_exp(mk(0, 0, 0, 1, 4'b0000), c + 1);
        push_exp(mk(0, 1, 1, 1, 4'b0100), c + 2);
        repeat (4) tick();

        // chan_done[2] with request still high: RELEASE, CPU slot of 2, then re-handoff.
        c = cyc;
        chan_done = 4'b0100;
        push_exp(mk(0, 0, 0, 1, 4'b0000), c + 1);
        push_exp(mk(0, 0, 0, 0, 4'b0000), c + 2);
        push_exp(mk(0, 0, 0, 1, 4'b0000), c + 5);
        push_exp(mk(0, 1, 1, 1, 4'b0100), c + 6);
        tick();
        chan_done = '0;
        repeat (6) tick();

        // Abort of channel 2 with channel 3 waiting: direct switch.
        c = cyc;
        dma_req = 4'b1000;
        push_exp(mk(0, 1, 1, 1, 4'b1000), c + 1);
        repeat (3) tick();

        // Channel 0 rises mid-unit of channel 3: waits for unit_done[3].
        dma_req = 4'b1001;
        repeat (3) tick();
        c = cyc;
        unit_done = 4'b1000;
        push_exp(mk(1, 1, 1, 1, 4'b0001), c + 1);
        push_exp(mk(0, 1, 1, 1, 4'b0001), c + 2);
        tick();
        unit_done = '0;
        repeat (3) tick();

        // Channel 1 owner; lower-priority channel 3 never preempts.
        c = cyc;
        dma_req = 4'b0010;
        push_exp(mk(0, 1, 1, 1, 4'b0010), c + 1);
        repeat (2) tick();
        dma_req = 4'b1010;
        repeat (2) tick();
        unit_done = 4'b0010;
        chan_done = 4'b0001;   // not granted: ignored
        tick();
        unit_done = '0;
        chan_done = '0;
        repeat (3) tick();
        c = cyc;
        chan_done = 4'b0010;
        push_exp(mk(0, 1, 1, 1, 4'b1000), c + 1);
        tick();
        chan_done = '0;
        dma_req   = 4'b1000;
        repeat (2) tick();

        // Preempt back to channel 0, then mem_wait freeze.
        dma_req = 4'b1001;
        tick();
        c = cyc;
        unit_done = 4'b1000;
        push_exp(mk(1, 1, 1, 1, 4'b0001), c + 1);
        push_exp(mk(0, 1, 1, 1, 4'b0001), c + 2);
        tick();
        unit_done = '0;
        repeat (2) tick();
        c = cyc;
        mem_wait  = 1'b1;
        chan_done = 4'b0001;
        tick();
        chan_done = '0;
        repeat (2) tick();
        chan_done = 4'b0001;
        repeat (2) tick();
        mem_wait = 1'b0;
        push_exp(mk(0, 1, 1, 1, 4'b1000), c + 6);
        tick();
        chan_done = '0;
        dma_req   = 4'b1000;
        repeat (2) tick();

        // Last channel finishes: release to CPU.
        c = cyc;
        chan_done = 4'b1000;
        dma_req   = '0;
        push_exp(mk(0, 0, 0, 1, 4'b0000), c + 1);
        push_exp(mk(0, 0, 0, 0, 4'b0000), c + 2);
        tick();
        chan_done = '0;
        repeat (5) tick();

        // HANDOFF without cpu_paused, request withdrawn after 4 cycles.
        c = cyc;
        cpu_paused = 1'b0;
        dma_req    = 4'b0100;
        push_exp(mk(0, 0, 0, 1, 4'b0000), c + 1);
        push_exp(mk(0, 0, 0, 0, 4'b0000), c + 5);
        repeat (4) tick();
        dma_req = '0;
        repeat (3) tick();

        // Grant channel 0, then asynchronous reset between clock edges.
        c = cyc;
        cpu_paused = 1'b1;
        dma_req    = 4'b0001;
        push_exp(mk(0, 0, 0, 1, 4'b0000), c + 1);
        push_exp(mk(0, 1, 1, 1, 4'b0001), c + 2);
        repeat (3) tick();
        #2;
        push_exp(mk(0, 0, 0, 0, 4'b0000), cyc);
        rst_b = 1'b0;
        #1;
        chk("async_reset_immediate", out_vec, '0);
        repeat (2) tick();
        rst_b = 1'b1;

        // Leaves reset in CPU_OWN with an empty slot: handoff right away.
        c = cyc;
        push_exp(mk(0, 0, 0, 1, 4'b0000), c + 1);
        push_exp(mk(0, 1, 1, 1, 4'b0001), c + 2);
        repeat (4) tick();
        c = cyc;
        chan_done = 4'b0001;
        dma_req   = '0;
        push_exp(mk(0, 0, 0, 1, 4'b0000), c + 1);
        push_exp(mk(0, 0, 0, 0, 4'b0000), c + 2);
        tick();
        chan_done = '0;
        repeat (4) tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Sequences ownership of the shared system memory bus between the CPU and the four DMA channels.
- Replaces the ad-hoc preempt / allowed_to_begin wiring at the DMA top level with one registered controller.
- Channel 0 has the highest fixed priority. Preemption happens only at unit boundaries, i.e. after a completed read+write pair.
- Requests a CPU pause, waits for the CPU's acknowledge, grants one channel at a time, then returns the bus to the CPU after a guaranteed CPU slot.

Parameters:
- NUM_CH, 4, number of DMA requesters; index 0 is the highest priority.
- CPU_SLOT, 2, minimum cycles the CPU owns the bus after each DMA release before a new handoff may begin; 0 allowed.

Ports:
- clk  input  1  system clock
- rst_b  input  1  reset; asynchronous, active-low
- dma_req  input  NUM_CH  channel has a started/queued transfer pending; level signal
- unit_done  input  NUM_CH  pulse: channel finished one read+write unit (write accepted)
- chan_done  input  NUM_CH  pulse: channel finished its whole transfer
- mem_wait  input  1  memory busy; bus must not change owner while high
- cpu_paused  input  1  CPU has completed its in-flight access and is stalled
- cpu_pause  output  1  request to the CPU to stall at its next access boundary
- grant  output  NUM_CH  one-hot channel grant, registered
- bus_sel_dma  output  1  address/data mux select: 1 = DMA drives the bus
- dma_active  output  1  any grant asserted (feeds the existing active output)
- preempt_evt  output  1  one-cycle pulse when the grant switches directly between channels

Behaviour:
- States: CPU_OWN, HANDOFF, DMA_OWN, RELEASE.
- Reset:
  - state CPU_OWN, slot counter 0.
  - grant=0, cpu_pause=0, bus_sel_dma=0, dma_active=0, preempt_evt=0.
  - Reset mid-transfer drops the grant immediately (async).
- All outputs are registered. bus_sel_dma = (state==DMA_OWN). dma_active = |grant.
- CPU_OWN:
  - Slot counter decrements to 0.
  - If |dma_req and counter==0: cpu_pause<=1, go to HANDOFF.
- HANDOFF:
  - cpu_pause held at 1.
  - If dma_req==0: go to CPU_OWN, cpu_pause<=0, counter untouched.
  - If cpu_paused && !mem_wait: grant<=lowest-index set bit of dma_req, sampled this cycle; go to DMA_OWN. Latency from request to grant is 2 cycles minimum when cpu_paused is already high.
- DMA_OWN, for the granted channel g:
  - Owner may change only on a cycle with mem_wait==0.
  - Channel g exits when chan_done[g], or when dma_req[g] falls (abort: enable cleared). The next grant is the lowest-index requester excluding g. If there is none, grant<=0 and go to RELEASE.
  - Preemption: on unit_done[g] with no exit, if any dma_req[i] with i<g is set, grant<=lowest such i and preempt_evt<=1. Otherwise g keeps the grant.
  - Lower-priority requests never preempt.
  - unit_done / chan_done on non-granted bits are ignored.
  - chan_done and unit_done in the same cycle: chan_done wins.
  - mem_wait high: all done pulses that cycle are ignored. Channels must hold chan_done, or re-pulse it, until mem_wait is low.
- RELEASE (1 cycle):
  - bus_sel_dma=0, cpu_pause<=0.
  - Slot counter<=CPU_SLOT; go to CPU_OWN.
  - With CPU_SLOT=0, a pending request re-enters HANDOFF on the next cycle.
- Direct channel-to-channel switches never pass through CPU_OWN.
- Invariant: grant is one-hot or zero; grant!=0 only in DMA_OWN.
- Slot counter is $clog2(CPU_SLOT+1) bits and saturates at 0.

Decomposition:
- Package dma_arb_pkg:
  - state enum (CPU_OWN, HANDOFF, DMA_OWN, RELEASE), 2 bits.
  - NUM_DMA_CH constant.
  - Default CPU_SLOT constant.
- Sub-module dma_prio_enc: NUM_CH-bit request vector plus exclude mask in; one-hot lowest-index winner and a valid flag out; purely combinational.
- The arbiter FSM instantiates it twice: normal pick and higher-than-g pick.

Test Plan:
- Reset, then dma_req=4'b0100, cpu_paused=1 → cpu_pause=1 at cycle 1, grant=4'b0100 and bus_sel_dma=1 at cycle 2. Then chan_done[2] → RELEASE, grant=0, cpu_pause=0, and no new HANDOFF for 2 cycles even with dma_req reasserted.
- Channel 3 granted; dma_req[0] rises mid-unit → grant stays 4'b1000 until unit_done[3]. Next edge: grant=4'b0001, preempt_evt=1 for one cycle, no pass through CPU_OWN.
- Channel 1 granted; dma_req[3] rises; unit_done[1] → grant stays 4'b0010 (no low-priority preemption). Then chan_done[1] → grant=4'b1000 directly.
- mem_wait=1 held 5 cycles while chan_done[0] pulses once, then is re-held until mem_wait falls → grant unchanged during the wait, switches only on the first mem_wait=0 cycle.
- HANDOFF with cpu_paused=0 for 4 cycles, then dma_req drops to 0 → return to CPU_OWN, cpu_pause=0, grant never asserted.
- Assert rst_b=0 while grant=4'b0001 → grant, bus_sel_dma and cpu_pause go 0 without waiting for a clock edge; state is CPU_OWN after release.
